element_cut_clamp_bipolar: RTL and testbench

//  Downstream stage of the bundling element-addition unit: walks an FP32 sum hypervector in memory and writes

---
 rtl/element_cut_clamp_bipolar.sv | 175 +++++++++++++++++
 tb/tb_element_cut_clamp_bipolar.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/element_cut_clamp_bipolar.sv
`default_nettype none
// ============================================================================
//  Module   : element_cut_clamp_bipolar
//  Purpose  : Walks an FP32 sum hypervector in memory one element at a time
//             and writes each element clamped to [CUT_NEG_FP, CUT_POS_FP] into
//             a destination vector (the "cut" bundle). Start/done handshake
//             to the bundling sequencer.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             start           - begin operation (sampled only when idle)
//             src_addr        - base address of FP32 input vector
//             dst_addr        - base address of output vector
//             busy, done      - run in progress / one-cycle completion pulse
//             we_n, waddress, data_wr - write port (we_n active low)
//             raddress, data_rd       - read port
//  Revision : 1.0  initial release
// ============================================================================
module element_cut_clamp_bipolar #(
    parameter int          HYPERVECTOR_DIMENSIONS = 1000,
    parameter logic [31:0] CUT_NEG_FP             = 32'hBF800000,
    parameter logic [31:0] CUT_POS_FP             = 32'h3F800000,
    parameter int          RD_LATENCY             = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] src_addr,
    input  logic [20:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic        we_n,
    output logic [20:0] waddress,
    output logic [31:0] data_wr,
    output logic [20:0] raddress,
    input  logic [31:0] data_rd
);

    localparam int c_addr_w = 21;
    localparam int c_idx_w  = (HYPERVECTOR_DIMENSIONS > 1) ? $clog2(HYPERVECTOR_DIMENSIONS) : 1;
    localparam int c_cnt_w  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state,    w_state;
    logic [c_addr_w-1:0]  r_src,      w_src;
    logic [c_addr_w-1:0]  r_dst,      w_dst;
    logic [c_idx_w-1:0]   r_idx,      w_idx;
    logic [c_cnt_w-1:0]   r_wait_cnt, w_wait_cnt;
    logic                 r_busy,     w_busy;
    logic                 r_done,     w_done;
    logic                 r_we_n,     w_we_n;
    logic [c_addr_w-1:0]  r_waddress, w_waddress;
    logic [31:0]          r_data_wr,  w_data_wr;
    logic [c_addr_w-1:0]  r_raddress, w_raddress;
    logic [31:0]          w_cut;

    // Strict "a < b" for non-NaN FP32 values in sign/magnitude form.
    // +0 and -0 compare equal; infinities fall out of the magnitude compare.
    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[31] != b[31])
            r = a[31] && ((a[30:0] | b[30:0]) != 31'd0);
        else if (!a[31])
            r = a[30:0] < b[30:0];
        else
            r = a[30:0] > b[30:0];
        return r;
    endfunction

    always_comb begin
        w_cut = data_rd;
        if ((data_rd[30:23] == 8'hFF) && (data_rd[22:0] != 23'd0))
            w_cut = 32'h00000000;
        else if (fp_lt(CUT_POS_FP, data_rd))
            w_cut = CUT_POS_FP;
        else if (fp_lt(data_rd, CUT_NEG_FP))
            w_cut = CUT_NEG_FP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_we_n     <= 1'b1;
            r_waddress <= '0;
            r_data_wr  <= '0;
            r_raddress <= '0;
        end else begin
            r_state    <= w_state;
            r_src      <= w_src;
            r_dst      <= w_dst;
            r_idx      <= w_idx;
            r_wait_cnt <= w_wait_cnt;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_we_n     <= w_we_n;
            r_waddress <= w_waddress;
            r_data_wr  <= w_data_wr;
            r_raddress <= w_raddress;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_src      = r_src;
        w_dst      = r_dst;
        w_idx      = r_idx;
        w_wait_cnt = r_wait_cnt;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_we_n     = 1'b1;
        w_waddress = r_waddress;
        w_data_wr  = r_data_wr;
        w_raddress = r_raddress;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src      = src_addr;
                    w_dst      = dst_addr;
                    w_idx      = '0;
                    w_raddress = src_addr;
                    w_busy     = 1'b1;
                    w_wait_cnt = '0;
                    w_state    = S_WAIT;
                end
            end
            S_WAIT: begin
                // Hold off the write until the read data for raddress is valid.
                if (r_wait_cnt == c_cnt_w'(RD_LATENCY - 1)) begin
                    w_wait_cnt = '0;
                    w_state    = S_WRITE;
                end else begin
                    w_wait_cnt = r_wait_cnt + c_cnt_w'(1);
                end
            end
            S_WRITE: begin
                w_data_wr  = w_cut;
                w_waddress = r_dst + c_addr_w'(r_idx);
                w_we_n     = 1'b0;
                if (r_idx == c_idx_w'(HYPERVECTOR_DIMENSIONS - 1)) begin
                    w_state = S_DONE;
                end else begin
                    w_idx      = r_idx + c_idx_w'(1);
                    w_raddress = r_src + c_addr_w'(r_idx) + 21'd1;
                    w_state    = S_WAIT;
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign we_n     = r_we_n;
    assign waddress = r_waddress;
    assign data_wr  = r_data_wr;
    assign raddress = r_raddress;

endmodule
`default_nettype wire

// File: tb/tb_element_cut_clamp_bipolar.sv
`default_nettype none
// ============================================================================
//  Module   : tb_element_cut_clamp_bipolar
//  Purpose  : Directed self-checking bench for element_cut_clamp_bipolar
//             (DIM=4, RD_LATENCY=1) with a behavioural memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_element_cut_clamp_bipolar;

    localparam int DIM = 4;
    localparam int NE  = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [20:0] src_addr;
    logic [20:0] dst_addr;
    logic        busy;
    logic        done;
    logic        we_n;
    logic [20:0] waddress;
    logic [31:0] data_wr;
    logic [20:0] raddress;
    logic [31:0] data_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    element_cut_clamp_bipolar #(
        .HYPERVECTOR_DIMENSIONS(DIM),
        .CUT_NEG_FP            (32'hBF800000),
        .CUT_POS_FP            (32'h3F800000),
        .RD_LATENCY            (1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .busy    (busy),
        .done    (done),
        .we_n    (we_n),
        .waddress(waddress),
        .data_wr (data_wr),
        .raddress(raddress),
        .data_rd (data_rd)
    );

    // Behavioural memory, one cycle read latency.
    logic [31:0] mem [logic [20:0]];
    always @(posedge clk) begin
        if (mem.exists(raddress)) data_rd <= mem[raddress];
        else                      data_rd <= 32'hDEADBEEF;
        if (!we_n) mem[waddress] = data_wr;
    end

    // Per-edge log of outputs, index = edges after the accepting edge.
    logic        l_we_n [NE];
    logic        l_done [NE];
    logic        l_busy [NE];
    logic [20:0] l_wa   [NE];
    logic [20:0] l_ra   [NE];
    logic [31:0] l_wd   [NE];
    logic [31:0] exp_d  [DIM];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [20:0] base, input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
        mem[base]         = v0;
        mem[base + 21'd1] = v1;
        mem[base + 21'd2] = v2;
        mem[base + 21'd3] = v3;
    endtask

    task automatic set_exp(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
        exp_d[0] = v0; exp_d[1] = v1; exp_d[2] = v2; exp_d[3] = v3;
    endtask

    // Starts a run; optionally pulses start (src=0x300) at edge 3 and/or
    // asserts reset so that it is sampled at edge rst_e+1.
    task automatic run(input logic [20:0] s, input logic [20:0] d, input bit inj, input int rst_e);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        start    = 1'b1;
        @(posedge clk);
        for (int e = 0; e < NE; e++) begin
            @(negedge clk);
            l_we_n[e] = we_n;
            l_done[e] = done;
            l_busy[e] = busy;
            l_wa[e]   = waddress;
            l_ra[e]   = raddress;
            l_wd[e]   = data_wr;
            if (e == 0) start = 1'b0;
            if (inj && e == 2) begin
                start = 1'b1; src_addr = 21'h300; dst_addr = 21'h380;
            end
            if (inj && e == 3) start = 1'b0;
            reset = (e == rst_e);
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input logic [20:0] d, input int n_exp);
        int nw = 0;
        for (int e = 0; e < NE; e++) begin
            if (l_we_n[e] == 1'b0) begin
                if (nw < DIM) begin
                    check({tag, "_waddr"}, {11'd0, l_wa[e]}, {11'd0, d + 21'(nw)});
                    check({tag, "_wdata"}, l_wd[e], exp_d[nw]);
                    check({tag, "_wedge"}, e, 2 * (nw + 1));
                end
                nw++;
            end
        end
        check({tag, "_nwrites"}, nw, n_exp);
    endtask

    task automatic check_reads(input string tag, input logic [20:0] s);
        for (int i = 0; i < DIM; i++)
            check({tag, "_raddr"}, {11'd0, l_ra[2 * i]}, {11'd0, s + 21'(i)});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_we_n", {31'd0, we_n}, 32'd1);
        check("rst_waddr", {11'd0, waddress}, 32'd0);
        check("rst_data_wr", data_wr, 32'd0);
        check("rst_raddr", {11'd0, raddress}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Basic clamp run plus handshake timing.
        load(21'h100, 32'h40200000, 32'hC0400000, 32'h3F000000, 32'h7FC00000);
        set_exp(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h00000000);
        run(21'h100, 21'h200, 1'b0, -1);
        check_writes("t1", 21'h200, DIM);
        check_reads("t1", 21'h100);
        for (int e = 0; e < NE; e++) begin
            check("t2_done", {31'd0, l_done[e]}, {31'd0, (e == 9) ? 1'b1 : 1'b0});
            check("t2_busy", {31'd0, l_busy[e]}, {31'd0, (e <= 8) ? 1'b1 : 1'b0});
        end

        // Infinities and signed zero, processed in place.
        load(21'h400, 32'h7F800000, 32'hFF800000, 32'h80000000, 32'h3F800000);
        set_exp(32'h3F800000, 32'hBF800000, 32'h80000000, 32'h3F800000);
        run(21'h400, 21'h400, 1'b0, -1);
        check_writes("t3", 21'h400, DIM);
        for (int i = 0; i < DIM; i++)
            check("t3_mem", mem[21'h400 + 21'(i)], exp_d[i]);

        // Just past the bounds, negative NaN, signalling NaN.
        load(21'h700, 32'hBF800001, 32'h3F800001, 32'hFFC00000, 32'h7F800001);
        set_exp(32'hBF800000, 32'h3F800000, 32'h00000000, 32'h00000000);
        run(21'h700, 21'h800, 1'b0, -1);
        check_writes("t3b", 21'h800, DIM);

        // Address wrap; denormals pass unchanged.
        load(21'h1FFFFE, 32'h3E800000, 32'hBF000000, 32'h00000001, 32'h807FFFFF);
        set_exp(32'h3E800000, 32'hBF000000, 32'h00000001, 32'h807FFFFF);
        run(21'h1FFFFE, 21'h1FFFFF, 1'b0, -1);
        check_reads("t4", 21'h1FFFFE);
        check_writes("t4", 21'h1FFFFF, DIM);

        // start while busy is ignored.
        load(21'h300, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        set_exp(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h00000000);
        run(21'h100, 21'h900, 1'b1, -1);
        check_reads("t5", 21'h100);
        check_writes("t5", 21'h900, DIM);

        // Reset after the second write aborts the run.
        load(21'h500, 32'h3F000000, 32'hBF000000, 32'h40000000, 32'hC0000000);
        set_exp(32'h3F000000, 32'hBF000000, 32'h3F800000, 32'hBF800000);
        run(21'h500, 21'h600, 1'b0, 4);
        check_writes("t6a", 21'h600, 2);
        check("t6_rst_we_n", {31'd0, l_we_n[5]}, 32'd1);
        check("t6_rst_waddr", {11'd0, l_wa[5]}, 32'd0);
        check("t6_rst_data_wr", l_wd[5], 32'd0);
        check("t6_rst_raddr", {11'd0, l_ra[5]}, 32'd0);
        check("t6_rst_busy", {31'd0, l_busy[5]}, 32'd0);
        check("t6_rst_done", {31'd0, l_done[5]}, 32'd0);
        run(21'h500, 21'h600, 1'b0, -1);
        check_writes("t6b", 21'h600, DIM);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
